// File: rtl/des_key_schedule_ctrl_if.sv
// ---------------------------------------------------------------------------
// des_key_schedule_ctrl_if
// Groups the key-load request and round-key stream of the DES key-schedule
// sequencer into one bundle.
//
// Signals
//   start     master->slave  begin schedule (sampled only while idle)
//   key_in    master->slave  64-bit DES key including parity bits
//   decrypt   master->slave  reverse key order (only with DES_KEY_DECRYPT_EN)
//   rk_ready  master->slave  consumer accepts rk_data this cycle
//   busy      slave->master  high from accepted start until done pulse
//   rk_valid  slave->master  round key available
//   rk_data   slave->master  48-bit round key (PC2 output)
//   rk_round  slave->master  issue index 0..15 of rk_data
//   done      slave->master  one-cycle pulse after the last key is accepted
//
// Modports
//   master : key loader / round pipeline side
//   slave  : des_key_schedule_ctrl side
// ---------------------------------------------------------------------------
interface des_key_schedule_ctrl_if;
  logic        start;
  logic [63:0] key_in;
  logic        decrypt;
  logic        rk_ready;
  logic        busy;
  logic        rk_valid;
  logic [47:0] rk_data;
  logic [3:0]  rk_round;
  logic        done;

  modport master (
    output start, key_in, decrypt, rk_ready,
    input  busy, rk_valid, rk_data, rk_round, done
  );

  modport slave (
    input  start, key_in, decrypt, rk_ready,
    output busy, rk_valid, rk_data, rk_round, done
  );
endinterface

// File: rtl/des_key_schedule_ctrl.sv
// ---------------------------------------------------------------------------
// des_key_schedule_ctrl
// Iterative DES key-schedule sequencer. A key is run through PC1 once when
// start is accepted; afterwards one registered stage rotates the 28-bit C/D
// halves per round, applies PC2 and offers each of the 16 round keys on a
// valid/ready stream. done pulses for one cycle after the last transfer.
//
// Parameters
//   SHIFT2_MASK  bit i set -> round i rotates by 2, else by 1
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    des_key_schedule_ctrl_if.slave (start/key_in/decrypt/rk_ready in,
//          busy/rk_valid/rk_data/rk_round/done out)
//
// Configuration macro
//   DES_KEY_DECRYPT_EN  when defined, decrypt is latched at start and a set
//                       value issues the keys as K16..K1. When undefined the
//                       decrypt input is ignored and only encrypt order exists.
// ---------------------------------------------------------------------------
module des_key_schedule_ctrl #(
  parameter logic [15:0] SHIFT2_MASK = 16'h7EFC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  des_key_schedule_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, ROUND, DRAIN} state_e;

  // Table entries are 1-based bit numbers counted from the key MSB.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int j = 0; j < 56; j++) r[55-j] = k[64-PC1_TAB[j]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2_TAB[j]];
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [27:0] c_rot, d_rot;
  logic [47:0] rk_data_q, rk_data_d;
  logic [3:0]  rk_round_q, rk_round_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        rk_valid_q, rk_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

`ifdef DES_KEY_DECRYPT_EN
  logic        dec_q, dec_d;
  logic [3:0]  dec_idx;

  // Decrypt walks the schedule backwards: round 0 reuses C0/D0 (equal to
  // C16/D16), later rounds undo encrypt round 16-rnd; -rnd mod 16 is that index.
  always_comb begin
    c_rot   = c_q;
    d_rot   = d_q;
    dec_idx = ~rnd_q + 4'd1;
    if (dec_q) begin
      if (rnd_q != 4'd0) begin
        if (SHIFT2_MASK[dec_idx]) begin
          c_rot = {c_q[1:0], c_q[27:2]};
          d_rot = {d_q[1:0], d_q[27:2]};
        end else begin
          c_rot = {c_q[0], c_q[27:1]};
          d_rot = {d_q[0], d_q[27:1]};
        end
      end
    end else if (SHIFT2_MASK[rnd_q]) begin
      c_rot = {c_q[25:0], c_q[27:26]};
      d_rot = {d_q[25:0], d_q[27:26]};
    end else begin
      c_rot = {c_q[26:0], c_q[27]};
      d_rot = {d_q[26:0], d_q[27]};
    end
  end
`else
  logic decrypt_unused;
  assign decrypt_unused = bus.decrypt;

  // Encrypt-only rotation of both halves for the current round.
  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    if (SHIFT2_MASK[rnd_q]) begin
      c_rot = {c_q[25:0], c_q[27:26]};
      d_rot = {d_q[25:0], d_q[27:26]};
    end else begin
      c_rot = {c_q[26:0], c_q[27]};
      d_rot = {d_q[26:0], d_q[27]};
    end
  end
`endif

  // Next-state logic. A new key is produced whenever the output slot is
  // empty or being consumed, so a stalled key stays frozen on the port.
  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    d_d        = d_q;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    rnd_d      = rnd_q;
    rk_valid_d = rk_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef DES_KEY_DECRYPT_EN
    dec_d      = dec_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          {c_d, d_d} = pc1(bus.key_in);
          rnd_d      = 4'd0;
          busy_d     = 1'b1;
          state_d    = ROUND;
`ifdef DES_KEY_DECRYPT_EN
          dec_d      = bus.decrypt;
`endif
        end
      end
      ROUND: begin
        if (!rk_valid_q || bus.rk_ready) begin
          c_d        = c_rot;
          d_d        = d_rot;
          rk_data_d  = pc2({c_rot, d_rot});
          rk_round_d = rnd_q;
          rk_valid_d = 1'b1;
          rnd_d      = rnd_q + 4'd1;
          if (rnd_q == 4'd15) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rk_valid_q && bus.rk_ready) begin
          rk_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      c_q        <= '0;
      d_q        <= '0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      rnd_q      <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DES_KEY_DECRYPT_EN
      dec_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      d_q        <= d_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      rnd_q      <= rnd_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DES_KEY_DECRYPT_EN
      dec_q      <= dec_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_data  = rk_data_q;
  assign bus.rk_round = rk_round_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_des_key_schedule_ctrl.sv
// ---------------------------------------------------------------------------
// tb_des_key_schedule_ctrl
// Directed testbench for des_key_schedule_ctrl. Expected round keys are the
// published DES schedule of key 133457799BBCDFF1. Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_des_key_schedule_ctrl;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  logic [47:0] expKey [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule_ctrl_if bus();

  des_key_schedule_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns on the falling edge just after the start-sampling rising edge.
  task automatic start_run(input logic [63:0] key, input logic dec);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_in  = key;
    bus.decrypt = dec;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic test_reset();
    logic found;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.busy, bus.rk_valid, bus.done} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got busy/valid/done=%b want 000", {bus.busy, bus.rk_valid, bus.done});
    end
    checks++;
    if ({bus.rk_round, bus.rk_data} !== 52'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got round=%0d data=%h want 0/0", bus.rk_round, bus.rk_data);
    end
    @(negedge clk);
    rst_n = 1'b1;

    bus.rk_ready = 1'b1;
    start_run(KEY, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.rk_valid && bus.rk_round == 4'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL reset_wait_r5: got no round 5 within 40 cycles, want round 5");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.rk_valid, bus.done, bus.rk_round, bus.rk_data} !== 55'h0) begin
      failures++;
      $display("[TB] FAIL reset_async: got busy=%b valid=%b done=%b round=%0d data=%h want all 0",
               bus.busy, bus.rk_valid, bus.done, bus.rk_round, bus.rk_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_run(KEY, 1'b0);
    @(negedge clk);
    checks++;
    if ({bus.rk_valid, bus.rk_round, bus.rk_data} !== {1'b1, 4'd0, expKey[0]}) begin
      failures++;
      $display("[TB] FAIL reset_restart: got valid=%b round=%0d data=%h want 1/0/%h",
               bus.rk_valid, bus.rk_round, bus.rk_data, expKey[0]);
    end
    apply_reset();
  endtask

  task automatic test_encrypt();
    bus.rk_ready = 1'b1;
    start_run(KEY, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.rk_valid, bus.rk_round, bus.rk_data} !== {1'b1, 1'b1, 4'(i), expKey[i]}) begin
        failures++;
        $display("[TB] FAIL enc_round%0d: got busy=%b valid=%b round=%0d data=%h want 1/1/%0d/%h",
                 i, bus.busy, bus.rk_valid, bus.rk_round, bus.rk_data, i, expKey[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.rk_valid, bus.done} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL enc_done: got busy/valid/done=%b want 001", {bus.busy, bus.rk_valid, bus.done});
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL enc_done_width: got busy/done=%b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_backpressure();
    int          idx;
    int          cyc;
    logic        stalled;
    logic [3:0]  prevRound;
    logic [47:0] prevData;
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    prevRound = '0;
    prevData = '0;
    bus.rk_ready = 1'b0;
    start_run(KEY, 1'b0);
    while (idx < 16 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        checks++;
        if ({bus.rk_valid, bus.rk_round, bus.rk_data} !== {1'b1, prevRound, prevData}) begin
          failures++;
          $display("[TB] FAIL bp_stall: got valid=%b round=%0d data=%h want 1/%0d/%h",
                   bus.rk_valid, bus.rk_round, bus.rk_data, prevRound, prevData);
        end
      end
      checks++;
      if (bus.done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_early_done: got done=%b want 0 after %0d transfers", bus.done, idx);
      end
      bus.rk_ready = 1'($urandom_range(0, 1));
      if (bus.rk_valid && bus.rk_ready) begin
        checks++;
        if ({bus.rk_round, bus.rk_data} !== {4'(idx), expKey[idx]}) begin
          failures++;
          $display("[TB] FAIL bp_order: got round=%0d data=%h want %0d/%h",
                   bus.rk_round, bus.rk_data, idx, expKey[idx]);
        end
        idx++;
        stalled = 1'b0;
      end else begin
        stalled   = bus.rk_valid;
        prevRound = bus.rk_round;
        prevData  = bus.rk_data;
      end
    end
    checks++;
    if (idx != 16) begin
      failures++;
      $display("[TB] FAIL bp_timeout: got %0d transfers want 16", idx);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.rk_valid, bus.done} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL bp_done: got busy/valid/done=%b want 001", {bus.busy, bus.rk_valid, bus.done});
    end
    bus.rk_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_during_busy();
    bus.rk_ready = 1'b1;
    start_run(KEY, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.rk_valid, bus.rk_round, bus.rk_data} !== {1'b1, 1'b1, 4'(i), expKey[i]}) begin
        failures++;
        $display("[TB] FAIL busy_round%0d: got busy=%b valid=%b round=%0d data=%h want 1/1/%0d/%h",
                 i, bus.busy, bus.rk_valid, bus.rk_round, bus.rk_data, i, expKey[i]);
      end
      if (i == 7) begin
        bus.start  = 1'b1;
        bus.key_in = 64'h0;
      end
      if (i == 8) bus.start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.rk_valid, bus.done} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL busy_done: got busy/valid/done=%b want 001", {bus.busy, bus.rk_valid, bus.done});
    end
    @(negedge clk);
  endtask

  task automatic test_zero_key();
    logic found;
    bus.rk_ready = 1'b1;
    start_run(64'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rk_valid, bus.rk_round, bus.rk_data} !== {1'b1, 4'(i), 48'h0}) begin
        failures++;
        $display("[TB] FAIL zero_round%0d: got valid=%b round=%0d data=%h want 1/%0d/0",
                 i, bus.rk_valid, bus.rk_round, bus.rk_data, i);
      end
      if (i == 15) begin
        bus.start  = 1'b1;
        bus.key_in = KEY;
      end
    end
    // start held through the done cycle: ignored in DRAIN, taken one cycle later
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.rk_valid, bus.done} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL zero_done: got busy/valid/done=%b want 001", {bus.busy, bus.rk_valid, bus.done});
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.rk_valid, bus.done} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL restart_after_done: got busy/valid/done=%b want 100", {bus.busy, bus.rk_valid, bus.done});
    end
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rk_valid, bus.rk_round, bus.rk_data} !== {1'b1, 4'd0, expKey[0]}) begin
      failures++;
      $display("[TB] FAIL restart_round0: got valid=%b round=%0d data=%h want 1/0/%h",
               bus.rk_valid, bus.rk_round, bus.rk_data, expKey[0]);
    end
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.done) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL restart_done_timeout: got no done within 40 cycles, want done");
    end
    @(negedge clk);
  endtask

  task automatic test_decrypt();
    logic [47:0] want;
    bus.rk_ready = 1'b1;
    start_run(KEY, 1'b1);
    for (int i = 0; i < 16; i++) begin
`ifdef DES_KEY_DECRYPT_EN
      want = expKey[15-i];
`else
      want = expKey[i];
`endif
      @(negedge clk);
      checks++;
      if ({bus.rk_valid, bus.rk_round, bus.rk_data} !== {1'b1, 4'(i), want}) begin
        failures++;
        $display("[TB] FAIL dec_round%0d: got valid=%b round=%0d data=%h want 1/%0d/%h",
                 i, bus.rk_valid, bus.rk_round, bus.rk_data, i, want);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL dec_done: got busy/done=%b want 01", {bus.busy, bus.done});
    end
    bus.decrypt = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.decrypt  = 1'b0;
    bus.rk_ready = 1'b0;
    rst_n        = 1'b0;
    test_reset();
    test_encrypt();
    test_backpressure();
    test_start_during_busy();
    test_zero_key();
    test_decrypt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
